// File: rtl/ise_color_stat.sv
// ise_color_stat: per-image colour statistics ahead of the ISE sorter.
// Classifies each pixel by its largest channel, accumulates per-colour
// pixel counts and channel sums, and emits one record per image.
//
// Handshakes:
//   pixel side  - a pixel is taken on a rising edge when in_valid && !busy;
//                 the source must hold pixel_in/image_in_index while busy.
//   record side - a record transfers on a rising edge when st_valid && st_ready;
//                 all st_* outputs hold steady while st_valid && !st_ready.
module ise_color_stat #(
    parameter int PIX_PER_IMG = 16384,
    parameter int CNT_W       = 15,
    parameter int SUM_W       = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [4:0]       image_in_index,
    input  logic [23:0]      pixel_in,
    output logic             busy,
    output logic             st_valid,
    input  logic             st_ready,
    output logic [4:0]       st_image_index,
    output logic [1:0]       st_color,
    output logic [CNT_W-1:0] st_count,
    output logic [SUM_W-1:0] st_sum,
    output logic             idx_err
);

    typedef enum logic {
        ACCUM = 1'b0,
        FINAL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_IMG - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             load;
    logic [7:0]       ch_r;
    logic [7:0]       ch_g;
    logic [7:0]       ch_b;
    logic [1:0]       pix_cls;
    logic [1:0]       dom_col;
    logic [CNT_W-1:0] dom_cnt;
    logic [SUM_W-1:0] dom_sum;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_g;
    logic [CNT_W-1:0] cnt_b;
    logic [CNT_W-1:0] pix_cnt;
    logic [SUM_W-1:0] sum_r;
    logic [SUM_W-1:0] sum_g;
    logic [SUM_W-1:0] sum_b;
    logic [4:0]       img_idx;

    assign ch_r = pixel_in[23:16];
    assign ch_g = pixel_in[15:8];
    assign ch_b = pixel_in[7:0];

    // Classify the incoming pixel by its largest channel, ties R > G > B.
    always_comb begin
        pix_cls = 2'd2;
        if (ch_r >= ch_g && ch_r >= ch_b)
            pix_cls = 2'd0;
        else if (ch_g >= ch_b)
            pix_cls = 2'd1;
    end

    // Pick the dominant colour of the finished image, ties R > G > B.
    always_comb begin
        dom_col = 2'd2;
        dom_cnt = cnt_b;
        dom_sum = sum_b;
        if (cnt_r >= cnt_g && cnt_r >= cnt_b) begin
            dom_col = 2'd0;
            dom_cnt = cnt_r;
            dom_sum = sum_r;
        end else if (cnt_g >= cnt_b) begin
            dom_col = 2'd1;
            dom_cnt = cnt_g;
            dom_sum = sum_g;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    // FSM next state: leave ACCUM on the last pixel, leave FINAL once the slot is free.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (in_valid && pix_cnt == LAST_PIX) state_nxt = FINAL;
            FINAL:   if (!st_valid || st_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // FSM outputs: busy is the FINAL state itself; load fires when the slot can take a record.
    always_comb begin
        busy   = (state == FINAL);
        accept = in_valid && (state == ACCUM);
        load   = (state == FINAL) && (!st_valid || st_ready);
    end

    // Accumulate counts and sums per accepted pixel; clear everything when the record loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= '0;
            cnt_g   <= '0;
            cnt_b   <= '0;
            sum_r   <= '0;
            sum_g   <= '0;
            sum_b   <= '0;
            pix_cnt <= '0;
            img_idx <= '0;
        end else if (load) begin
            cnt_r   <= '0;
            cnt_g   <= '0;
            cnt_b   <= '0;
            sum_r   <= '0;
            sum_g   <= '0;
            sum_b   <= '0;
            pix_cnt <= '0;
        end else if (accept) begin
            case (pix_cls)
                2'd0:    cnt_r <= cnt_r + CNT_W'(1);
                2'd1:    cnt_g <= cnt_g + CNT_W'(1);
                default: cnt_b <= cnt_b + CNT_W'(1);
            endcase
            sum_r   <= sum_r + SUM_W'(ch_r);
            sum_g   <= sum_g + SUM_W'(ch_g);
            sum_b   <= sum_b + SUM_W'(ch_b);
            pix_cnt <= pix_cnt + CNT_W'(1);
            if (pix_cnt == '0)
                img_idx <= image_in_index;
        end
    end

    // Sticky flag: a later pixel of an image carried a different index than the first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            idx_err <= 1'b0;
        else if (accept && pix_cnt != '0 && image_in_index != img_idx)
            idx_err <= 1'b1;
    end

    // Output record register: load wins over a same-edge handshake so nothing is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_valid       <= 1'b0;
            st_image_index <= '0;
            st_color       <= '0;
            st_count       <= '0;
            st_sum         <= '0;
        end else if (load) begin
            st_valid       <= 1'b1;
            st_image_index <= img_idx;
            st_color       <= dom_col;
            st_count       <= dom_cnt;
            st_sum         <= dom_sum;
        end else if (st_ready) begin
            st_valid       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ise_color_stat.sv
// Testbench for ise_color_stat: a small-image instance (4 pixels) carries the
// directed and randomized checks, a default-size instance covers the full image.
module tb_ise_color_stat;

    localparam int SP    = 4;
    localparam int SC    = 3;
    localparam int SS    = 10;
    localparam int REC_W = 5 + 2 + SC + SS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- small instance ----------------
    logic          in_valid;
    logic [4:0]    image_in_index;
    logic [23:0]   pixel_in;
    logic          busy;
    logic          st_valid;
    logic          st_ready;
    logic [4:0]    st_image_index;
    logic [1:0]    st_color;
    logic [SC-1:0] st_count;
    logic [SS-1:0] st_sum;
    logic          idx_err;

    ise_color_stat #(.PIX_PER_IMG(SP), .CNT_W(SC), .SUM_W(SS)) u_small (
        .clk(clk), .reset(rst_n), .in_valid(in_valid),
        .image_in_index(image_in_index), .pixel_in(pixel_in), .busy(busy),
        .st_valid(st_valid), .st_ready(st_ready), .st_image_index(st_image_index),
        .st_color(st_color), .st_count(st_count), .st_sum(st_sum), .idx_err(idx_err)
    );

    // ---------------- default-size instance ----------------
    logic        in_valid_b;
    logic [4:0]  image_in_index_b;
    logic [23:0] pixel_in_b;
    logic        busy_b;
    logic        st_valid_b;
    logic        st_ready_b;
    logic [4:0]  st_image_index_b;
    logic [1:0]  st_color_b;
    logic [14:0] st_count_b;
    logic [21:0] st_sum_b;
    logic        idx_err_b;

    ise_color_stat u_big (
        .clk(clk), .reset(rst_n), .in_valid(in_valid_b),
        .image_in_index(image_in_index_b), .pixel_in(pixel_in_b), .busy(busy_b),
        .st_valid(st_valid_b), .st_ready(st_ready_b), .st_image_index(st_image_index_b),
        .st_color(st_color_b), .st_count(st_count_b), .st_sum(st_sum_b), .idx_err(idx_err_b)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [REC_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: class counts and channel sums from plain integer arithmetic.
    function automatic logic [REC_W-1:0] model(input logic [4:0] idx, input logic [23:0] px[SP]);
        int cnt[3];
        int sum[3];
        int v[3];
        int c;
        int d;
        for (int j = 0; j < 3; j++) begin
            cnt[j] = 0;
            sum[j] = 0;
        end
        for (int i = 0; i < SP; i++) begin
            v[0] = int'(px[i][23:16]);
            v[1] = int'(px[i][15:8]);
            v[2] = int'(px[i][7:0]);
            if (v[0] >= v[1] && v[0] >= v[2]) c = 0;
            else if (v[1] >= v[2])            c = 1;
            else                              c = 2;
            cnt[c]++;
            for (int j = 0; j < 3; j++) sum[j] += v[j];
        end
        if (cnt[0] >= cnt[1] && cnt[0] >= cnt[2]) d = 0;
        else if (cnt[1] >= cnt[2])                d = 1;
        else                                      d = 2;
        return {idx, 2'(d), SC'(cnt[d]), SS'(sum[d])};
    endfunction

    function automatic logic [23:0] rand_px();
        logic [7:0] ch[3];
        for (int j = 0; j < 3; j++) begin
            case ($urandom_range(0, 3))
                0:       ch[j] = 8'h00;
                1:       ch[j] = 8'h80;
                2:       ch[j] = 8'hFF;
                default: ch[j] = 8'($urandom_range(0, 255));
            endcase
        end
        return {ch[0], ch[1], ch[2]};
    endfunction

    // ---------------- driver tasks ----------------
    // Present one pixel and hold it until a non-busy edge takes it.
    task automatic send_pixel(input logic [4:0] idx, input logic [23:0] px);
        bit done = 1'b0;
        int k = 0;
        in_valid = 1'b1;
        image_in_index = idx;
        pixel_in = px;
        while (!done && k < 100) begin
            done = !busy;
            @(posedge clk);
            #1;
            k++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got busy=%0b required pixel accepted within 100 cycles", busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_image(input logic [4:0] idx[SP], input logic [23:0] px[SP],
                              input int max_gap, input bit push);
        if (push) exp_q.push_back(model(idx[0], px));
        for (int i = 0; i < SP; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            send_pixel(idx[i], px[i]);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     64'(busy), 64'd0);
        check({tag, "_st_valid"}, 64'(st_valid), 64'd0);
        check({tag, "_st_index"}, 64'(st_image_index), 64'd0);
        check({tag, "_st_color"}, 64'(st_color), 64'd0);
        check({tag, "_st_count"}, 64'(st_count), 64'd0);
        check({tag, "_st_sum"},   64'(st_sum), 64'd0);
        check({tag, "_idx_err"},  64'(idx_err), 64'd0);
    endtask

    // ---------------- monitor ----------------
    logic [REC_W-1:0] mon_act;
    logic [REC_W-1:0] held;
    bit hold_prev = 1'b0;

    // Pop and compare on every handshake; also require a held record to stay put.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            mon_act = {st_image_index, st_color, st_count, st_sum};
            if (hold_prev && st_valid)
                check("held_record_stable", 64'(mon_act), 64'(held));
            if (st_valid && st_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_record: got %0h required no record", mon_act);
                end else begin
                    check("record", 64'(mon_act), 64'(exp_q.pop_front()));
                end
            end
            hold_prev = st_valid && !st_ready;
            held = mon_act;
        end
    end

    int busy_b_cycles = 0;
    // Count high cycles of the default-size instance's busy.
    always @(negedge clk) begin
        if (rst_n && busy_b) busy_b_cycles++;
    end

    // ---------------- main sequence ----------------
    logic [4:0]  ia[SP];
    logic [23:0] pa[SP];
    int          busy_start;
    bit          seen;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        image_in_index = '0;
        pixel_in = '0;
        st_ready = 1'b1;
        in_valid_b = 1'b0;
        image_in_index_b = '0;
        pixel_in_b = '0;
        st_ready_b = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Classification and tie handling.
        for (int i = 0; i < SP; i++) ia[i] = 5'd5;
        pa = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h808080};
        exp_q.push_back({5'd5, 2'd0, 3'd2, 10'h17F});
        send_image(ia, pa, 0, 1'b0);
        drain();
        check("idx_err_clean", 64'(idx_err), 64'd0);

        // Index changes on the 3rd pixel: flag sets, record keeps the first index.
        ia = '{5'd9, 5'd9, 5'd10, 5'd9};
        for (int i = 0; i < SP; i++) pa[i] = rand_px();
        send_image(ia, pa, 1, 1'b1);
        drain();
        check("idx_err_set", 64'(idx_err), 64'd1);

        // Back-pressure: two images finish while the sorter refuses.
        st_ready = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            for (int i = 0; i < SP; i++) begin
                ia[i] = 5'(n);
                pa[i] = rand_px();
            end
            send_image(ia, pa, 0, 1'b1);
        end
        repeat (3) @(posedge clk);
        #1;
        check("bp_busy_held", 64'(busy), 64'd1);
        check("bp_valid_held", 64'(st_valid), 64'd1);
        check("bp_record1_held", 64'({st_image_index, st_color, st_count, st_sum}), 64'(exp_q[0]));
        st_ready = 1'b1;
        @(posedge clk);
        #1;
        st_ready = 1'b0;
        check("bp_busy_dropped", 64'(busy), 64'd0);
        check("bp_valid_after_swap", 64'(st_valid), 64'd1);
        check("bp_record2_loaded", 64'({st_image_index, st_color, st_count, st_sum}), 64'(exp_q[0]));
        st_ready = 1'b1;
        drain();

        // 32-image stream with random in_valid gaps.
        for (int n = 0; n < 32; n++) begin
            for (int i = 0; i < SP; i++) begin
                ia[i] = 5'(n);
                pa[i] = rand_px();
            end
            send_image(ia, pa, 3, 1'b1);
        end
        drain();
        check("idx_err_sticky", 64'(idx_err), 64'd1);

        // Reset mid-image with a record pending: all discarded without a clock.
        st_ready = 1'b0;
        for (int i = 0; i < SP; i++) begin
            ia[i] = 5'd3;
            pa[i] = rand_px();
        end
        send_image(ia, pa, 0, 1'b1);
        send_pixel(5'd4, rand_px());
        send_pixel(5'd4, rand_px());
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        st_ready = 1'b1;
        for (int i = 0; i < SP; i++) begin
            ia[i] = 5'd20;
            pa[i] = rand_px();
        end
        send_image(ia, pa, 1, 1'b1);
        drain();
        check("idx_err_after_rst", 64'(idx_err), 64'd0);

        // Default-size image, all pixels 10F020.
        busy_start = busy_b_cycles;
        image_in_index_b = 5'd7;
        pixel_in_b = 24'h10F020;
        for (int i = 0; i < 16384; i++) begin
            seen = 1'b0;
            in_valid_b = 1'b1;
            for (int k = 0; k < 20 && !seen; k++) begin
                seen = !busy_b;
                @(posedge clk);
                #1;
            end
        end
        in_valid_b = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (st_valid_b) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("big_valid", 64'(seen), 64'd1);
        check("big_index", 64'(st_image_index_b), 64'd7);
        check("big_color", 64'(st_color_b), 64'd1);
        check("big_count", 64'(st_count_b), 64'd16384);
        check("big_sum", 64'(st_sum_b), 64'h3C0000);
        repeat (3) @(posedge clk);
        #1;
        check("big_valid_cleared", 64'(st_valid_b), 64'd0);
        check("big_busy_one_cycle", 64'(busy_b_cycles - busy_start), 64'd1);
        check("big_idx_err", 64'(idx_err_b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ise_color_stat.md
# ise_color_stat

Per-image colour statistics stage sitting directly upstream of the ISE sorting core. It accepts the raw 24-bit RGB pixel stream tagged with a 5-bit image index, classifies every pixel by its largest channel, and accumulates per-colour pixel counts and channel sums. At the end of each image it emits one record to the sorter over a valid/ready handshake: image index, dominant colour, and that colour's pixel count and channel sum. It applies back-pressure to the pixel source with `busy`.

## Interface
- `PIX_PER_IMG`, default 16384: pixels per image (128×128); must be a power of two ≥ 2.
- `CNT_W`, default 15: counter width; must hold `PIX_PER_IMG`.
- `SUM_W`, default 22: channel-sum width; must hold `PIX_PER_IMG`×255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `in_valid` in 1: pixel present on `pixel_in`/`image_in_index`.
- `image_in_index` in 5: image tag of the current pixel.
- `pixel_in` in 24: {R[23:16], G[15:8], B[7:0]}.
- `busy` out 1: pixel not accepted this cycle; source holds the pixel.
- `st_valid` out 1: result record valid.
- `st_ready` in 1: sorter accepts the record.
- `st_image_index` out 5: image index of the record.
- `st_color` out 2: dominant colour, 0=R, 1=G, 2=B; 3 never driven.
- `st_count` out CNT_W: number of pixels classified as `st_color`.
- `st_sum` out SUM_W: sum of the `st_color` channel over all pixels of the image.
- `idx_err` out 1: sticky; an image-index mismatch was seen inside an image.

## Operation
- Acceptance: a pixel is accepted on a rising edge when `in_valid && !busy`.
- Pixel class: R if R≥G and R≥B; otherwise G if G≥B; otherwise B. Ties resolve R > G > B.
- Per accepted pixel: increment the class counter (`cnt_r`/`cnt_g`/`cnt_b`). Add R, G and B to `sum_r`, `sum_g` and `sum_b` respectively, unconditionally for every pixel. Increment `pix_cnt`.
- Image index: latched from the pixel accepted with `pix_cnt==0`. On any later pixel of the same image whose index differs, set `idx_err`. `idx_err` is cleared only by reset.
- FSM ACCUM (reset state): accept pixels. When the accepted pixel has `pix_cnt==PIX_PER_IMG-1`, go to FINAL. That pixel is included in the totals.
- FSM FINAL: `busy=1`. Dominant colour is the largest of the three counters, with ties R > G > B.
  - If the output slot is free (`!st_valid || st_ready`), load the record: `st_count` = dominant counter, `st_sum` = dominant sum. Then clear all counters, sums and `pix_cnt`, and go to ACCUM.
  - Otherwise stay in FINAL.
- Output register: `st_valid` sets when the record loads. It clears on `st_valid && st_ready` unless a new record loads in the same edge, in which case it stays 1 with the new data.
- All `st_*` outputs are stable while `st_valid && !st_ready`.
- Widths: the counters and sums never overflow at the default parameters; no saturation logic is provided.
- `busy` is purely `state==FINAL`.

## Timing
- Reset values: `busy=0`, `st_valid=0`, `st_image_index=0`, `st_color=0`, `st_count=0`, `st_sum=0`, `idx_err=0`. The FSM resets to ACCUM and all counters to 0.
- Latency: last pixel accepted at edge N → `busy=1` during cycle N→N+1 → record loaded and `st_valid=1` after edge N+1 (slot free case).
- The minimum `busy` pulse per image is one cycle. It extends by exactly the number of cycles that `st_valid && !st_ready` persists.
- Throughput: `PIX_PER_IMG+1` cycles per image with the sorter always ready.
- Simultaneous events: sorter acceptance of the old record and load of the new record in the same edge is legal. No record is lost or duplicated.
- A reset assertion mid-image or mid-FINAL discards the partial image and any pending record immediately, with no clock required.
- `in_valid` low stalls accumulation only. The FSM and output path continue to run.

## Test plan
- Reset: drive `reset=0` mid-image, release → all outputs at reset values. The next accepted pixel is counted as `pix_cnt=0` of a new image.
- Classification/ties (`PIX_PER_IMG=4`): image 5 with pixels FF0000, 00FF00, 0000FF, 808080 → counts R=2, G=1, B=1. Record: index 5, colour 0, count 2, sum `sum_r`=0xFF+0x80=0x17F.
- Default size, all pixels 10F020 for image 7 → `st_color=1`, `st_count=16384`, `st_sum=16384×0xF0=0x3C0000`. `busy` is high exactly one cycle.
- Back-pressure (`PIX_PER_IMG=4`, `st_ready=0`): image 1 completes, then image 2 completes → `busy` stays high with record 1 held stable. Raising `st_ready` for one cycle → record 2 loads on that same edge and `busy` drops the following cycle.
- `in_valid` gaps: random idle cycles inserted in a 32-image stream with `st_ready=1` → 32 records, in order, each matching the golden model.
- Index error: change `image_in_index` on the 3rd pixel of an image → `idx_err=1`, held until reset. The record still uses the index latched from the first pixel.
